// File: rtl/rto_pkg.sv
// Shared types for the RTO event scheduler: queued entry layout and dispatch state.
package rto_pkg;

  localparam int unsigned ENTRY_W = 128;
  localparam int unsigned TS_MSB  = 127;
  localparam int unsigned TS_LSB  = 64;

  typedef struct packed {
    logic [63:0] timestamp;
    logic [63:0] payload;
  } entry_t;

  typedef enum logic {
    StIdle,
    StRun
  } state_e;

endpackage

// File: rtl/rto_sync_fifo.sv
// Single-clock entry FIFO with a registered read port; the read register doubles as
// the scheduler's prefetch (head) register.
module rto_sync_fifo
  import rto_pkg::*;
#(
  parameter int unsigned DEPTH = 1024
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   flush_i,
  input  logic   wr_en_i,
  input  entry_t wr_data_i,
  input  logic   rd_en_i,
  output entry_t rd_data_o,
  output logic   empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PtrOne = 1;

  entry_t      mem_q [DEPTH];
  entry_t      rd_data_q;
  logic [AW:0] wr_ptr_q, rd_ptr_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

  // Extra pointer MSB distinguishes full from empty; low bits wrap modulo DEPTH.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_data_q <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en_i) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (rd_en_i) begin
        rd_ptr_q  <= rd_ptr_q + PtrOne;
        rd_data_q <= mem_q[rd_ptr_q[AW-1:0]];
      end
    end
  end

  assign rd_data_o = rd_data_q;
  assign empty_o   = (wr_ptr_q == rd_ptr_q);

endmodule

// File: rtl/rto_event_scheduler.sv
// Timestamped event scheduler: queues entries and dispatches each when the global
// counter reaches its timestamp, flagging late entries and overflowing writes.
module rto_event_scheduler
  import rto_pkg::*;
#(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned THRESHOLD = 1000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         auto_start,
  input  logic         flush,
  input  logic         write,
  input  logic [127:0] fifo_din,
  input  logic [63:0]  counter,
  output logic         counter_matched,
  output logic [127:0] rto_out,
  output logic         timestamp_error,
  output logic         overflow_error,
  output logic [127:0] timestamp_error_data,
  output logic [127:0] overflow_error_data,
  output logic         full,
  output logic         empty,
  output logic         almost_full
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  state_e        state_q, state_d;
  logic [CW-1:0] occ_q, occ_d;
  logic          head_valid_q, head_valid_d;
  entry_t        head;
  logic          fifo_empty, rd_en, wr_en;
  logic          dispatch, ts_match, ts_late, pop, is_full, overflow;

  logic         matched_q, ts_err_q, ovf_err_q;
  logic [127:0] rto_out_q, ts_err_data_q, ovf_err_data_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (auto_start) state_d = StRun;
      StRun:   state_d = StRun;
      default: state_d = StIdle;
    endcase
  end

  assign ts_match = head_valid_q && (counter == head[TS_MSB:TS_LSB]);
  assign ts_late  = head_valid_q && (counter > head[TS_MSB:TS_LSB]);
  // Flush wins over dispatch so a flushed head never strobes.
  assign dispatch = (state_q == StRun) && !flush;
  assign pop      = dispatch && (ts_match || ts_late);
  assign is_full  = (occ_q == CW'(DEPTH));
  assign wr_en    = write && !flush && (!is_full || pop);
  assign overflow = write && !flush && is_full && !pop;
  // Refill the head whenever it is empty or leaving this cycle.
  assign rd_en    = !flush && !fifo_empty && (!head_valid_q || pop);

  always_comb begin
    head_valid_d = head_valid_q;
    occ_d        = occ_q + CW'(wr_en) - CW'(pop);
    if (flush) begin
      head_valid_d = 1'b0;
      occ_d        = '0;
    end else if (rd_en) begin
      head_valid_d = 1'b1;
    end else if (pop) begin
      head_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      occ_q          <= '0;
      head_valid_q   <= 1'b0;
      matched_q      <= 1'b0;
      ts_err_q       <= 1'b0;
      ovf_err_q      <= 1'b0;
      rto_out_q      <= '0;
      ts_err_data_q  <= '0;
      ovf_err_data_q <= '0;
    end else begin
      state_q      <= state_d;
      occ_q        <= occ_d;
      head_valid_q <= head_valid_d;
      matched_q    <= dispatch && ts_match;
      ts_err_q     <= dispatch && ts_late;
      ovf_err_q    <= overflow;
      if (dispatch && ts_match) rto_out_q <= head;
      if (dispatch && ts_late) ts_err_data_q <= head;
      if (overflow) ovf_err_data_q <= fifo_din;
    end
  end

  rto_sync_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i    (clk),
    .rst_i    (reset),
    .flush_i  (flush),
    .wr_en_i  (wr_en),
    .wr_data_i(entry_t'(fifo_din)),
    .rd_en_i  (rd_en),
    .rd_data_o(head),
    .empty_o  (fifo_empty)
  );

  assign counter_matched      = matched_q;
  assign rto_out              = rto_out_q;
  assign timestamp_error      = ts_err_q;
  assign timestamp_error_data = ts_err_data_q;
  assign overflow_error       = ovf_err_q;
  assign overflow_error_data  = ovf_err_data_q;
  assign full                 = is_full;
  assign empty                = (occ_q == '0);
  assign almost_full          = (occ_q >= CW'(THRESHOLD));

endmodule

// File: tb/tb_rto_event_scheduler.sv
// Directed testbench for rto_event_scheduler with hand-computed expectations.
module tb_rto_event_scheduler;

  logic         clk = 1'b0;
  logic         reset, auto_start, flush, write;
  logic [127:0] fifo_din;
  logic [63:0]  counter;
  logic         counter_matched, timestamp_error, overflow_error;
  logic [127:0] rto_out, timestamp_error_data, overflow_error_data;
  logic         full, empty, almost_full;

  int tests_run    = 0;
  int tests_failed = 0;

  rto_event_scheduler dut (
    .clk                 (clk),
    .reset               (reset),
    .auto_start          (auto_start),
    .flush               (flush),
    .write               (write),
    .fifo_din            (fifo_din),
    .counter             (counter),
    .counter_matched     (counter_matched),
    .rto_out             (rto_out),
    .timestamp_error     (timestamp_error),
    .overflow_error      (overflow_error),
    .timestamp_error_data(timestamp_error_data),
    .overflow_error_data (overflow_error_data),
    .full                (full),
    .empty               (empty),
    .almost_full         (almost_full)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; auto_start = 1'b0; flush = 1'b0; write = 1'b0;
    fifo_din = '0; counter = '0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL rst_empty got %0b want 1", empty); end
    tests_run++; if (full !== 1'b0) begin tests_failed++; $display("FAIL rst_full got %0b want 0", full); end
    tests_run++; if (almost_full !== 1'b0) begin tests_failed++; $display("FAIL rst_af got %0b want 0", almost_full); end
    tests_run++; if ({counter_matched, timestamp_error, overflow_error} !== 3'b000) begin tests_failed++; $display("FAIL rst_strobes got %b want 000", {counter_matched, timestamp_error, overflow_error}); end
    tests_run++; if (rto_out !== 128'd0) begin tests_failed++; $display("FAIL rst_rto_out got %h want 0", rto_out); end
    tests_run++; if ((timestamp_error_data | overflow_error_data) !== 128'd0) begin tests_failed++; $display("FAIL rst_err_data got %h/%h want 0", timestamp_error_data, overflow_error_data); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_dispatch();
    logic exp_m;
    for (int i = 0; i < 3; i++) begin
      fifo_din = {64'(100 + i), 64'(64'hA000 + 100 + i)}; write = 1'b1; step();
    end
    write = 1'b0; counter = 64'd50; auto_start = 1'b1; step();
    auto_start = 1'b0;
    for (int c = 51; c <= 105; c++) begin
      counter = 64'(c); step();
      exp_m = (c >= 100) && (c <= 102);
      tests_run++; if (counter_matched !== exp_m) begin tests_failed++; $display("FAIL disp_strobe c=%0d got %0b want %0b", c, counter_matched, exp_m); end
      tests_run++; if (timestamp_error !== 1'b0) begin tests_failed++; $display("FAIL disp_no_te c=%0d got %0b want 0", c, timestamp_error); end
      if (exp_m) begin
        tests_run++; if (rto_out !== {64'(c), 64'(64'hA000 + c)}) begin tests_failed++; $display("FAIL disp_data c=%0d got %h", c, rto_out); end
      end
    end
    tests_run++; if (rto_out !== {64'd102, 64'hA066}) begin tests_failed++; $display("FAIL disp_hold got %h want %h", rto_out, {64'd102, 64'hA066}); end
  endtask

  task automatic test_latency();
    counter = 64'd200; fifo_din = {64'd200, 64'h55}; write = 1'b1; step();
    write = 1'b0;
    tests_run++; if (counter_matched !== 1'b0) begin tests_failed++; $display("FAIL lat_n1 got %0b want 0", counter_matched); end
    step();
    tests_run++; if (counter_matched !== 1'b0) begin tests_failed++; $display("FAIL lat_n2 got %0b want 0", counter_matched); end
    step();
    tests_run++; if (counter_matched !== 1'b1) begin tests_failed++; $display("FAIL lat_n3 got %0b want 1", counter_matched); end
    tests_run++; if (rto_out !== {64'd200, 64'h55}) begin tests_failed++; $display("FAIL lat_data got %h", rto_out); end
  endtask

  task automatic test_late();
    counter = 64'd20; fifo_din = {64'd10, 64'h77}; write = 1'b1; step();
    write = 1'b0; step(); step();
    tests_run++; if (timestamp_error !== 1'b1) begin tests_failed++; $display("FAIL late_te got %0b want 1", timestamp_error); end
    tests_run++; if (timestamp_error_data !== {64'd10, 64'h77}) begin tests_failed++; $display("FAIL late_data got %h", timestamp_error_data); end
    tests_run++; if (counter_matched !== 1'b0) begin tests_failed++; $display("FAIL late_no_cm got %0b want 0", counter_matched); end
    step();
    tests_run++; if (timestamp_error !== 1'b0) begin tests_failed++; $display("FAIL late_one_cycle got %0b want 0", timestamp_error); end
  endtask

  task automatic test_overflow();
    do_reset(); reset = 1'b0; step();
    for (int i = 0; i < 1024; i++) begin
      fifo_din = {64'(5000 + i), 64'(i)}; write = 1'b1; step();
      if (i == 998) begin
        tests_run++; if (almost_full !== 1'b0) begin tests_failed++; $display("FAIL af_999 got %0b want 0", almost_full); end
      end
      if (i == 999) begin
        tests_run++; if (almost_full !== 1'b1) begin tests_failed++; $display("FAIL af_1000 got %0b want 1", almost_full); end
      end
      if (i == 1022) begin
        tests_run++; if (full !== 1'b0) begin tests_failed++; $display("FAIL full_1023 got %0b want 0", full); end
      end
    end
    tests_run++; if (full !== 1'b1) begin tests_failed++; $display("FAIL full_1024 got %0b want 1", full); end
    fifo_din = 128'hDEAD; step();
    write = 1'b0;
    tests_run++; if (overflow_error !== 1'b1) begin tests_failed++; $display("FAIL ovf_strobe got %0b want 1", overflow_error); end
    tests_run++; if (overflow_error_data !== 128'hDEAD) begin tests_failed++; $display("FAIL ovf_data got %h want dead", overflow_error_data); end
    step();
    tests_run++; if ({overflow_error, full} !== 2'b01) begin tests_failed++; $display("FAIL ovf_after got %b want 01", {overflow_error, full}); end
  endtask

  task automatic test_full_pop_write();
    counter = 64'd0; auto_start = 1'b1; step();
    auto_start = 1'b0;
    counter = 64'd5000; fifo_din = {64'd9000, 64'hBEEF}; write = 1'b1; step();
    write = 1'b0; counter = 64'd0;
    tests_run++; if (counter_matched !== 1'b1) begin tests_failed++; $display("FAIL fpw_cm got %0b want 1", counter_matched); end
    tests_run++; if (rto_out !== {64'd5000, 64'd0}) begin tests_failed++; $display("FAIL fpw_data got %h", rto_out); end
    tests_run++; if (overflow_error !== 1'b0) begin tests_failed++; $display("FAIL fpw_no_ovf got %0b want 0", overflow_error); end
    tests_run++; if (full !== 1'b1) begin tests_failed++; $display("FAIL fpw_full got %0b want 1", full); end
    step();
    tests_run++; if (full !== 1'b1) begin tests_failed++; $display("FAIL fpw_full2 got %0b want 1", full); end
  endtask

  task automatic test_flush();
    do_reset(); reset = 1'b0; step();
    for (int i = 0; i < 5; i++) begin
      fifo_din = {64'(300 + i), 64'(8'h30 + i)}; write = 1'b1; step();
    end
    write = 1'b0; auto_start = 1'b1; step();
    auto_start = 1'b0; step();
    counter = 64'd300; flush = 1'b1; step();
    flush = 1'b0;
    tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL flush_empty got %0b want 1", empty); end
    tests_run++; if ({counter_matched, timestamp_error} !== 2'b00) begin tests_failed++; $display("FAIL flush_strobe got %b want 00", {counter_matched, timestamp_error}); end
    counter = 64'd400; fifo_din = {64'd400, 64'h40}; write = 1'b1; step();
    write = 1'b0;
    tests_run++; if ({counter_matched, timestamp_error} !== 2'b00) begin tests_failed++; $display("FAIL flush_residue got %b want 00", {counter_matched, timestamp_error}); end
    step(); step();
    tests_run++; if (counter_matched !== 1'b1) begin tests_failed++; $display("FAIL flush_still_run got %0b want 1", counter_matched); end
    tests_run++; if (rto_out !== {64'd400, 64'h40}) begin tests_failed++; $display("FAIL flush_run_data got %h", rto_out); end
  endtask

  task automatic test_reset_mid_run();
    counter = 64'd0;
    for (int i = 0; i < 3; i++) begin
      fifo_din = {64'(500 + i), 64'(8'h50 + i)}; write = 1'b1; step();
    end
    write = 1'b0; step(); step();
    counter = 64'd500; reset = 1'b1; #2;
    tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL rmid_empty got %0b want 1", empty); end
    tests_run++; if (rto_out !== 128'd0) begin tests_failed++; $display("FAIL rmid_rto_out got %h want 0", rto_out); end
    step();
    tests_run++; if ({counter_matched, timestamp_error, overflow_error} !== 3'b000) begin tests_failed++; $display("FAIL rmid_strobes got %b want 000", {counter_matched, timestamp_error, overflow_error}); end
    reset = 1'b0;
    counter = 64'd600; fifo_din = {64'd600, 64'h60}; write = 1'b1; step();
    write = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      tests_run++; if ({counter_matched, timestamp_error} !== 2'b00) begin tests_failed++; $display("FAIL rmid_idle k=%0d got %b want 00", k, {counter_matched, timestamp_error}); end
    end
    auto_start = 1'b1; step();
    auto_start = 1'b0;
    tests_run++; if (counter_matched !== 1'b0) begin tests_failed++; $display("FAIL rmid_start_cycle got %0b want 0", counter_matched); end
    step();
    tests_run++; if (counter_matched !== 1'b1) begin tests_failed++; $display("FAIL rmid_restart got %0b want 1", counter_matched); end
    tests_run++; if (rto_out !== {64'd600, 64'h60}) begin tests_failed++; $display("FAIL rmid_data got %h", rto_out); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired: got timeout want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_dispatch();
    test_latency();
    test_late();
    test_overflow();
    test_full_pop_write();
    test_flush();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
